// File: rtl/branch_resolve_queue_if.sv
// Bus between the pipeline and the branch resolve queue: allocate at D,
// resolve at M, PHT training channel and branch statistics.
interface branch_resolve_queue_if #(
   parameter int GHR_W = 4,
   parameter int IDX_W = 14
);
   logic             alloc_valid;
   logic [31:0]      alloc_pc;
   logic             alloc_pred;
   logic [GHR_W-1:0] alloc_ghr;
   logic             alloc_full;
   logic             res_valid;
   logic             res_take;
   logic [31:0]      res_target;
   logic             res_ready;
   logic             squash;
   logic             mispred;
   logic [31:0]      redirect_pc;
   logic [GHR_W-1:0] restore_ghr;
   logic             upd_valid;
   logic             upd_ready;
   logic [IDX_W-1:0] upd_index;
   logic             upd_take;
   logic [31:0]      stat_br;
   logic [31:0]      stat_mis;

   modport master (
      output alloc_valid, alloc_pc, alloc_pred, alloc_ghr,
      output res_valid, res_take, res_target, squash, upd_ready,
      input  alloc_full, res_ready, mispred, redirect_pc, restore_ghr,
      input  upd_valid, upd_index, upd_take, stat_br, stat_mis
   );

   modport slave (
      input  alloc_valid, alloc_pc, alloc_pred, alloc_ghr,
      input  res_valid, res_take, res_target, squash, upd_ready,
      output alloc_full, res_ready, mispred, redirect_pc, restore_ghr,
      output upd_valid, upd_index, upd_take, stat_br, stat_mis
   );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches popped at resolve; detects mispredictions,
// restores committed history and feeds PHT training through a small update FIFO.
module branch_resolve_queue #(
   parameter int QDEPTH = 4,
   parameter int GHR_W  = 4,
   parameter int IDX_W  = 14,
   parameter int UDEPTH = 2
) (
   input logic                   clk,
   input logic                   rst_n,
   branch_resolve_queue_if.slave bus
);
   localparam int QPW = $clog2(QDEPTH);
   localparam int UPW = $clog2(UDEPTH);
   localparam logic [QPW:0] QFULL = (QPW+1)'(QDEPTH);
   localparam logic [QPW:0] QONE  = (QPW+1)'(1);
   localparam logic [UPW:0] UFULL = (UPW+1)'(UDEPTH);
   localparam logic [UPW:0] UONE  = (UPW+1)'(1);

   logic [31:0]      qPc   [QDEPTH];
   logic [GHR_W-1:0] qGhr  [QDEPTH];
   logic [QDEPTH-1:0] qPred;
   logic [QPW:0]     qHead, qTail, qCount;

   logic [IDX_W-1:0] uIdx  [UDEPTH];
   logic [UDEPTH-1:0] uTake;
   logic [UPW:0]     uHead, uTail, uCount;

   logic [GHR_W-1:0] ghrCommit;
   logic             mispredReg;
   logic [31:0]      redirectReg;
   logic [GHR_W-1:0] restoreReg;
   logic [31:0]      statBr, statMis;

   logic             qFull, uFull, updFire, resReady, resFire, allocFire, misNow, clearQ;
   logic [31:0]      headPc;
   logic [GHR_W-1:0] headGhr;
   logic             headPred;

   // Occupancy, handshakes and misprediction detection for the current cycle.
   always_comb begin
      qCount    = qTail - qHead;
      uCount    = uTail - uHead;
      qFull     = (qCount == QFULL);
      uFull     = (uCount == UFULL);
      headPc    = qPc[qHead[QPW-1:0]];
      headGhr   = qGhr[qHead[QPW-1:0]];
      headPred  = qPred[qHead[QPW-1:0]];
      updFire   = (uCount != '0) & bus.upd_ready;
      resReady  = ~uFull | updFire;
      resFire   = bus.res_valid & resReady & (qCount != '0);
      // A pop frees the slot, so an alloc at full is taken when a resolve lands too.
      allocFire = bus.alloc_valid & (~qFull | resFire);
      misNow    = resFire & (bus.res_take != headPred) & ~bus.squash;
      clearQ    = bus.squash | misNow;
   end

   assign bus.alloc_full  = qFull;
   assign bus.res_ready   = resReady;
   assign bus.upd_valid   = (uCount != '0);
   assign bus.upd_index   = uIdx[uHead[UPW-1:0]];
   assign bus.upd_take    = uTake[uHead[UPW-1:0]];
   assign bus.mispred     = mispredReg;
   assign bus.redirect_pc = redirectReg;
   assign bus.restore_ghr = restoreReg;
   assign bus.stat_br     = statBr;
   assign bus.stat_mis    = statMis;

   // Branch queue: squash or mispredict discards everything, wrong-path alloc included.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qHead <= '0;
         qTail <= '0;
         qPred <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            qPc[i]  <= 32'd0;
            qGhr[i] <= '0;
         end
      end else if (clearQ) begin
         qHead <= '0;
         qTail <= '0;
      end else begin
         if (allocFire) begin
            qPc[qTail[QPW-1:0]]   <= bus.alloc_pc;
            qGhr[qTail[QPW-1:0]]  <= bus.alloc_ghr;
            qPred[qTail[QPW-1:0]] <= bus.alloc_pred;
            qTail                 <= qTail + QONE;
         end
         if (resFire) begin
            qHead <= qHead + QONE;
         end
      end
   end

   // PHT update FIFO; training happens even for squashed resolves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         uHead <= '0;
         uTail <= '0;
         uTake <= '0;
         for (int i = 0; i < UDEPTH; i++) begin
            uIdx[i] <= '0;
         end
      end else begin
         if (resFire) begin
            uIdx[uTail[UPW-1:0]]  <= {headPc[11:2], headGhr};
            uTake[uTail[UPW-1:0]] <= bus.res_take;
            uTail                 <= uTail + UONE;
         end
         if (updFire) begin
            uHead <= uHead + UONE;
         end
      end
   end

   // Committed history, redirect outputs and saturating statistics.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ghrCommit   <= '0;
         mispredReg  <= 1'b0;
         redirectReg <= 32'd0;
         restoreReg  <= '0;
         statBr      <= 32'd0;
         statMis     <= 32'd0;
      end else begin
         mispredReg <= misNow;
         if (resFire) begin
            ghrCommit <= {ghrCommit[GHR_W-2:0], bus.res_take};
            if (statBr != 32'hFFFF_FFFF) begin
               statBr <= statBr + 32'd1;
            end
         end
         if (misNow) begin
            redirectReg <= bus.res_take ? bus.res_target : (headPc + 32'd8);
            restoreReg  <= {ghrCommit[GHR_W-2:0], bus.res_take};
            if (statMis != 32'hFFFF_FFFF) begin
               statMis <= statMis + 32'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: vector table for the single-cycle
// behaviour plus hand-written sequences for back-pressure, squash and async reset.
module tb_branch_resolve_queue;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   logic [13:0] drained[$];

   branch_resolve_queue_if #(.GHR_W(4), .IDX_W(14)) bus ();

   branch_resolve_queue #(.QDEPTH(4), .GHR_W(4), .IDX_W(14), .UDEPTH(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic aV; logic [31:0] aPc; logic aPred; logic [3:0] aGhr;
      logic rV; logic rTake; logic [31:0] rTgt;
      logic sq; logic uRdy;
      logic eFull; logic eMis; logic [31:0] eRedir; logic [3:0] eRest;
      logic eUV; logic [13:0] eIdx; logic eUT;
      logic [31:0] eBr; logic [31:0] eMc;
   } vec_t;

   localparam int NV = 27;
   vec_t vt [NV];

   // Record every update that the PHT side accepts on the coming edge.
   always @(negedge clk) begin
      if (rst_n && bus.upd_valid && bus.upd_ready) drained.push_back(bus.upd_index);
   end

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.alloc_valid = 1'b0; bus.alloc_pc = 32'd0; bus.alloc_pred = 1'b0; bus.alloc_ghr = 4'd0;
      bus.res_valid = 1'b0; bus.res_take = 1'b0; bus.res_target = 32'd0; bus.squash = 1'b0;
   endtask

   task automatic alloc(input logic [31:0] pc, input logic pred, input logic [3:0] ghr);
      bus.alloc_valid = 1'b1; bus.alloc_pc = pc; bus.alloc_pred = pred; bus.alloc_ghr = ghr;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      // aV aPc pred ghr | rV take tgt | sq uRdy | eFull eMis eRedir eRest | eUV eIdx eUT | eBr eMc
      vt[0]  = '{1'b1,32'h0040_0010,1'b1,4'h0, 1'b0,1'b0,32'h0, 1'b0,1'b1, 1'b0,1'b0,32'h0,4'h0, 1'b0,14'h000,1'b0, 32'd0,32'd0};
      vt[1]  = '{1'b1,32'h0040_0014,1'b1,4'h1, 1'b0,1'b0,32'h0, 1'b0,1'b1, 1'b0,1'b0,32'h0,4'h0, 1'b0,14'h000,1'b0, 32'd0,32'd0};
      vt[2]  = '{1'b1,32'h0040_0018,1'b1,4'h3, 1'b0,1'b0,32'h0, 1'b0,1'b1, 1'b0,1'b0,32'h0,4'h0, 1'b0,14'h000,1'b0, 32'd0,32'd0};
      vt[3]  = '{1'b0,32'h0,1'b0,4'h0, 1'b1,1'b1,32'h0, 1'b0,1'b1, 1'b0,1'b0,32'h0,4'h0, 1'b1,14'h040,1'b1, 32'd1,32'd0};
      vt[4]  = '{1'b0,32'h0,1'b0,4'h0, 1'b1,1'b1,32'h0, 1'b0,1'b1, 1'b0,1'b0,32'h0,4'h0, 1'b1,14'h051,1'b1, 32'd2,32'd0};
      vt[5]  = '{1'b0,32'h0,1'b0,4'h0, 1'b1,1'b1,32'h0, 1'b0,1'b1, 1'b0,1'b0,32'h0,4'h0, 1'b1,14'h063,1'b1, 32'd3,32'd0};
      vt[6]  = '{1'b0,32'h0,1'b0,4'h0, 1'b0,1'b0,32'h0, 1'b0,1'b1, 1'b0,1'b0,32'h0,4'h0, 1'b0,14'h000,1'b0, 32'd3,32'd0};
      vt[7]  = '{1'b1,32'h0040_0010,1'b0,4'hA, 1'b0,1'b0,32'h0, 1'b0,1'b1, 1'b0,1'b0,32'h0,4'h0, 1'b0,14'h000,1'b0, 32'd3,32'd0};
      vt[8]  = '{1'b0,32'h0,1'b0,4'h0, 1'b1,1'b1,32'h0040_0100, 1'b0,1'b1, 1'b0,1'b1,32'h0040_0100,4'hF, 1'b1,14'h04A,1'b1, 32'd4,32'd1};
      vt[9]  = '{1'b0,32'h0,1'b0,4'h0, 1'b1,1'b0,32'h0, 1'b0,1'b1, 1'b0,1'b0,32'h0,4'h0, 1'b0,14'h000,1'b0, 32'd4,32'd1};
      vt[10] = '{1'b1,32'h0040_0020,1'b1,4'h6, 1'b0,1'b0,32'h0, 1'b0,1'b1, 1'b0,1'b0,32'h0,4'h0, 1'b0,14'h000,1'b0, 32'd4,32'd1};
      vt[11] = '{1'b0,32'h0,1'b0,4'h0, 1'b1,1'b0,32'h1234_5678, 1'b0,1'b1, 1'b0,1'b1,32'h0040_0028,4'hE, 1'b1,14'h086,1'b0, 32'd5,32'd2};
      vt[12] = '{1'b0,32'h0,1'b0,4'h0, 1'b0,1'b0,32'h0, 1'b0,1'b1, 1'b0,1'b0,32'h0,4'h0, 1'b0,14'h000,1'b0, 32'd5,32'd2};
      vt[13] = '{1'b1,32'h0040_0030,1'b0,4'h0, 1'b0,1'b0,32'h0, 1'b0,1'b1, 1'b0,1'b0,32'h0,4'h0, 1'b0,14'h000,1'b0, 32'd5,32'd2};
      vt[14] = '{1'b1,32'h0040_0034,1'b1,4'h0, 1'b1,1'b1,32'h0040_0200, 1'b0,1'b1, 1'b0,1'b1,32'h0040_0200,4'hD, 1'b1,14'h0C0,1'b1, 32'd6,32'd3};
      vt[15] = '{1'b0,32'h0,1'b0,4'h0, 1'b1,1'b1,32'h0, 1'b0,1'b1, 1'b0,1'b0,32'h0,4'h0, 1'b0,14'h000,1'b0, 32'd6,32'd3};
      vt[16] = '{1'b1,32'h0040_0040,1'b1,4'h0, 1'b0,1'b0,32'h0, 1'b0,1'b1, 1'b0,1'b0,32'h0,4'h0, 1'b0,14'h000,1'b0, 32'd6,32'd3};
      vt[17] = '{1'b1,32'h0040_0044,1'b1,4'h0, 1'b0,1'b0,32'h0, 1'b0,1'b1, 1'b0,1'b0,32'h0,4'h0, 1'b0,14'h000,1'b0, 32'd6,32'd3};
      vt[18] = '{1'b1,32'h0040_0048,1'b1,4'h0, 1'b0,1'b0,32'h0, 1'b0,1'b1, 1'b0,1'b0,32'h0,4'h0, 1'b0,14'h000,1'b0, 32'd6,32'd3};
      vt[19] = '{1'b1,32'h0040_004C,1'b1,4'h0, 1'b0,1'b0,32'h0, 1'b0,1'b1, 1'b1,1'b0,32'h0,4'h0, 1'b0,14'h000,1'b0, 32'd6,32'd3};
      vt[20] = '{1'b1,32'h0040_0050,1'b1,4'h0, 1'b0,1'b0,32'h0, 1'b0,1'b1, 1'b1,1'b0,32'h0,4'h0, 1'b0,14'h000,1'b0, 32'd6,32'd3};
      vt[21] = '{1'b1,32'h0040_0054,1'b1,4'h5, 1'b1,1'b1,32'h0, 1'b0,1'b1, 1'b1,1'b0,32'h0,4'h0, 1'b1,14'h100,1'b1, 32'd7,32'd3};
      vt[22] = '{1'b0,32'h0,1'b0,4'h0, 1'b1,1'b1,32'h0, 1'b0,1'b1, 1'b0,1'b0,32'h0,4'h0, 1'b1,14'h110,1'b1, 32'd8,32'd3};
      vt[23] = '{1'b0,32'h0,1'b0,4'h0, 1'b1,1'b1,32'h0, 1'b0,1'b1, 1'b0,1'b0,32'h0,4'h0, 1'b1,14'h120,1'b1, 32'd9,32'd3};
      vt[24] = '{1'b0,32'h0,1'b0,4'h0, 1'b1,1'b1,32'h0, 1'b0,1'b1, 1'b0,1'b0,32'h0,4'h0, 1'b1,14'h130,1'b1, 32'd10,32'd3};
      vt[25] = '{1'b0,32'h0,1'b0,4'h0, 1'b1,1'b1,32'h0, 1'b0,1'b1, 1'b0,1'b0,32'h0,4'h0, 1'b1,14'h155,1'b1, 32'd11,32'd3};
      vt[26] = '{1'b0,32'h0,1'b0,4'h0, 1'b1,1'b1,32'h0, 1'b0,1'b1, 1'b0,1'b0,32'h0,4'h0, 1'b0,14'h000,1'b0, 32'd11,32'd3};

      idle();
      bus.upd_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst.alloc_full", 32'(bus.alloc_full), 32'd0);
      check("rst.res_ready", 32'(bus.res_ready), 32'd1);
      check("rst.mispred", 32'(bus.mispred), 32'd0);
      check("rst.upd_valid", 32'(bus.upd_valid), 32'd0);
      check("rst.redirect", bus.redirect_pc, 32'd0);
      check("rst.stat_br", bus.stat_br, 32'd0);
      check("rst.stat_mis", bus.stat_mis, 32'd0);
      #2 rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         bus.alloc_valid = vt[i].aV; bus.alloc_pc = vt[i].aPc;
         bus.alloc_pred = vt[i].aPred; bus.alloc_ghr = vt[i].aGhr;
         bus.res_valid = vt[i].rV; bus.res_take = vt[i].rTake; bus.res_target = vt[i].rTgt;
         bus.squash = vt[i].sq; bus.upd_ready = vt[i].uRdy;
         tick();
         check($sformatf("v%0d.alloc_full", i), 32'(bus.alloc_full), 32'(vt[i].eFull));
         check($sformatf("v%0d.mispred", i), 32'(bus.mispred), 32'(vt[i].eMis));
         if (vt[i].eMis) begin
            check($sformatf("v%0d.redirect", i), bus.redirect_pc, vt[i].eRedir);
            check($sformatf("v%0d.restore", i), 32'(bus.restore_ghr), 32'(vt[i].eRest));
         end
         check($sformatf("v%0d.upd_valid", i), 32'(bus.upd_valid), 32'(vt[i].eUV));
         if (vt[i].eUV) begin
            check($sformatf("v%0d.upd_index", i), 32'(bus.upd_index), 32'(vt[i].eIdx));
            check($sformatf("v%0d.upd_take", i), 32'(bus.upd_take), 32'(vt[i].eUT));
         end
         check($sformatf("v%0d.stat_br", i), bus.stat_br, vt[i].eBr);
         check($sformatf("v%0d.stat_mis", i), bus.stat_mis, vt[i].eMc);
      end
      idle();

      // Update back-pressure: third resolve is held until the PHT accepts.
      bus.upd_ready = 1'b0;
      alloc(32'h0040_0060, 1'b1, 4'h1); tick();
      alloc(32'h0040_0064, 1'b1, 4'h2); tick();
      alloc(32'h0040_0068, 1'b1, 4'h3); tick();
      idle();
      drained.delete();
      bus.res_valid = 1'b1; bus.res_take = 1'b1;
      #1 check("bp.ready1", 32'(bus.res_ready), 32'd1);
      tick();
      #1 check("bp.ready2", 32'(bus.res_ready), 32'd1);
      tick();
      #1 check("bp.ready_held", 32'(bus.res_ready), 32'd0);
      tick();
      check("bp.br_held", bus.stat_br, 32'd13);
      check("bp.idx_held", 32'(bus.upd_index), 32'h181);
      tick();
      check("bp.idx_stable", 32'(bus.upd_index), 32'h181);
      bus.upd_ready = 1'b1;
      #1 check("bp.ready_pass", 32'(bus.res_ready), 32'd1);
      tick();
      bus.res_valid = 1'b0;
      check("bp.br_after", bus.stat_br, 32'd14);
      for (int k = 0; k < 10 && bus.upd_valid; k++) tick();
      check("bp.drain_done", 32'(bus.upd_valid), 32'd0);
      check("bp.drain_count", 32'(drained.size()), 32'd3);
      if (drained.size() == 3) begin
         check("bp.drain0", 32'(drained[0]), 32'h181);
         check("bp.drain1", 32'(drained[1]), 32'h192);
         check("bp.drain2", 32'(drained[2]), 32'h1A3);
      end

      // Squash beats a same-cycle alloc; the following resolve finds an empty queue.
      alloc(32'h0040_0070, 1'b1, 4'h0); tick();
      alloc(32'h0040_0074, 1'b1, 4'h0); tick();
      alloc(32'h0040_0078, 1'b1, 4'h0); bus.squash = 1'b1; tick();
      idle();
      bus.res_valid = 1'b1; bus.res_take = 1'b1; tick();
      idle();
      check("sq.br_ignored", bus.stat_br, 32'd14);
      check("sq.upd_none", 32'(bus.upd_valid), 32'd0);
      check("sq.no_mispred", 32'(bus.mispred), 32'd0);

      // Squash with an accepted mispredicting resolve: trains, counts, no redirect.
      alloc(32'h0040_007C, 1'b0, 4'h0); tick();
      idle();
      bus.squash = 1'b1; bus.res_valid = 1'b1; bus.res_take = 1'b1; bus.res_target = 32'h0040_0500;
      tick();
      idle();
      check("sqr.mispred", 32'(bus.mispred), 32'd0);
      check("sqr.stat_br", bus.stat_br, 32'd15);
      check("sqr.stat_mis", bus.stat_mis, 32'd3);
      check("sqr.upd_valid", 32'(bus.upd_valid), 32'd1);
      check("sqr.upd_index", 32'(bus.upd_index), 32'h1F0);

      // Mispredict with PHT stalled, then an asynchronous reset mid-drain.
      bus.upd_ready = 1'b0;
      alloc(32'h0040_0080, 1'b1, 4'h0); tick();
      idle();
      bus.res_valid = 1'b1; bus.res_take = 1'b0; tick();
      idle();
      check("mr.mispred", 32'(bus.mispred), 32'd1);
      check("mr.redirect", bus.redirect_pc, 32'h0040_0088);
      check("mr.restore", 32'(bus.restore_ghr), 32'hE);
      check("mr.stat_mis", bus.stat_mis, 32'd4);
      #2 rst_n = 1'b0;
      #1;
      check("ar.mispred", 32'(bus.mispred), 32'd0);
      check("ar.redirect", bus.redirect_pc, 32'd0);
      check("ar.restore", 32'(bus.restore_ghr), 32'd0);
      check("ar.upd_valid", 32'(bus.upd_valid), 32'd0);
      check("ar.stat_br", bus.stat_br, 32'd0);
      check("ar.stat_mis", bus.stat_mis, 32'd0);
      check("ar.res_ready", 32'(bus.res_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("ar.post_full", 32'(bus.alloc_full), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
